// File: rtl/kp_midi_pkg.sv
// Shared state types and MIDI constants for the Karplus-Strong voice controller.
package kp_midi_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_KEY,
        P_VEL,
        P_SKIP2,
        P_SKIP1
    } parse_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_LOW,
        T_GAP
    } trig_state_e;

    localparam logic [3:0]  NOTE_OFF  = 4'h8;
    localparam logic [3:0]  NOTE_ON   = 4'h9;
    localparam logic [7:0]  SYSRT_MIN = 8'hF8;
    localparam int unsigned FS_HZ     = 96000;
    localparam logic [11:0] DELAY_MAX = 12'd4095;

endpackage

// File: rtl/kp_note_period_rom.sv
// Key number -> delay-line length in samples: round(FS_HZ / f(key)), clamped to DELAY_MAX.
// Synchronous 128x12 ROM with one cycle of read latency.
module kp_note_period_rom
    import kp_midi_pkg::*;
(
    input  logic        i_clk,
    input  logic [6:0]  i_key,
    output logic [11:0] o_delay
);

    localparam logic [11:0] PERIOD [128] = '{
        DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX,
        DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX,
        DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, DELAY_MAX, 12'd3918, 12'd3698,
        12'd3491, 12'd3295, 12'd3110, 12'd2935, 12'd2771, 12'd2615,
        12'd2468, 12'd2330, 12'd2199, 12'd2076, 12'd1959, 12'd1849,
        12'd1745, 12'd1647, 12'd1555, 12'd1468, 12'd1385, 12'd1308,
        12'd1234, 12'd1165, 12'd1100, 12'd1038, 12'd980,  12'd925,
        12'd873,  12'd824,  12'd778,  12'd734,  12'd693,  12'd654,
        12'd617,  12'd582,  12'd550,  12'd519,  12'd490,  12'd462,
        12'd436,  12'd412,  12'd389,  12'd367,  12'd346,  12'd327,
        12'd309,  12'd291,  12'd275,  12'd259,  12'd245,  12'd231,
        12'd218,  12'd206,  12'd194,  12'd183,  12'd173,  12'd163,
        12'd154,  12'd146,  12'd137,  12'd130,  12'd122,  12'd116,
        12'd109,  12'd103,  12'd97,   12'd92,   12'd87,   12'd82,
        12'd77,   12'd73,   12'd69,   12'd65,   12'd61,   12'd58,
        12'd55,   12'd51,   12'd49,   12'd46,   12'd43,   12'd41,
        12'd39,   12'd36,   12'd34,   12'd32,   12'd31,   12'd29,
        12'd27,   12'd26,   12'd24,   12'd23,   12'd22,   12'd20,
        12'd19,   12'd18,   12'd17,   12'd16,   12'd15,   12'd14,
        12'd14,   12'd13,   12'd12,   12'd11,   12'd11,   12'd10,
        12'd10,   12'd9,    12'd9,    12'd8,    12'd8
    };

    logic [11:0] r_delay;

    always_ff @(posedge i_clk) begin
        r_delay <= PERIOD[i_key];
    end

    assign o_delay = r_delay;

endmodule

// File: rtl/kp_midi_voice_ctrl.sv
// Single-channel MIDI note parser driving the Karplus-Strong voice trigger.
// Define KP_MIDI_OMNI_EN to accept note messages on every channel.
module kp_midi_voice_ctrl
    import kp_midi_pkg::*;
#(
    parameter int unsigned TRIG_LEN      = 16,
    parameter logic [11:0] DEFAULT_DELAY = 12'd218
) (
    input  logic        i_audio_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_midi_byte,
    input  logic        i_midi_valid,
    input  logic [3:0]  i_midi_chan,
    output logic        o_trig,
    output logic [6:0]  o_velocity,
    output logic [11:0] o_delay_length,
    output logic        o_note_active,
    output logic [6:0]  o_last_note
);

    localparam int unsigned    CNT_W    = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIG_LEN - 1);

    parse_state_e     r_pstate, w_pstate_d;
    trig_state_e      r_tstate, w_tstate_d;
    logic             r_is_on, w_is_on_d;
    logic             r_skip_two, w_skip_two_d;
    logic [6:0]       r_key, w_key_d;
    logic             r_pend, w_pend_d;
    logic [6:0]       r_pend_key, w_pend_key_d;
    logic [6:0]       r_pend_vel, w_pend_vel_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_trig;
    logic [6:0]       r_velocity;
    logic [11:0]      r_delay;
    logic             r_active;
    logic [6:0]       r_last_note;

    logic             w_req;
    logic             w_off;
    logic             w_chan_ok;
    logic             w_is_rt;
    logic [3:0]       w_hi;
    logic [6:0]       w_rom_addr;
    logic [11:0]      w_rom_data;

    assign w_hi    = i_midi_byte[7:4];
    assign w_is_rt = (i_midi_byte >= SYSRT_MIN);

`ifdef KP_MIDI_OMNI_EN
    logic w_unused_chan;
    assign w_unused_chan = ^i_midi_chan;
    assign w_chan_ok     = 1'b1;
`else
    assign w_chan_ok = (i_midi_byte[3:0] == i_midi_chan);
`endif

    // Parser: running status is implicit, completed messages loop back to their first data state.
    always_comb begin
        w_pstate_d   = r_pstate;
        w_is_on_d    = r_is_on;
        w_skip_two_d = r_skip_two;
        w_key_d      = r_key;
        w_req        = 1'b0;
        w_off        = 1'b0;
        if (i_midi_valid) begin
            if (i_midi_byte[7]) begin
                if (w_is_rt) begin
                    w_pstate_d = r_pstate;
                end else if (w_hi == 4'hF) begin
                    w_pstate_d = P_IDLE;
                end else if ((w_hi == NOTE_ON || w_hi == NOTE_OFF) && w_chan_ok) begin
                    w_pstate_d = P_KEY;
                    w_is_on_d  = (w_hi == NOTE_ON);
                end else if (w_hi == 4'hC || w_hi == 4'hD) begin
                    w_pstate_d   = P_SKIP1;
                    w_skip_two_d = 1'b0;
                end else begin
                    w_pstate_d   = P_SKIP2;
                    w_skip_two_d = 1'b1;
                end
            end else begin
                unique case (r_pstate)
                    P_KEY: begin
                        w_key_d    = i_midi_byte[6:0];
                        w_pstate_d = P_VEL;
                    end
                    P_VEL: begin
                        if (r_is_on && (i_midi_byte[6:0] != 7'd0)) begin
                            w_req = 1'b1;
                        end else begin
                            w_off = 1'b1;
                        end
                        w_pstate_d = P_KEY;
                    end
                    P_SKIP2: w_pstate_d = P_SKIP1;
                    P_SKIP1: w_pstate_d = r_skip_two ? P_SKIP2 : P_SKIP1;
                    default: w_pstate_d = r_pstate;
                endcase
            end
        end
    end

    // Trigger FSM with a single overwrite-on-newest pending slot.
    always_comb begin
        w_tstate_d   = r_tstate;
        w_cnt_d      = r_cnt;
        w_pend_d     = r_pend;
        w_pend_key_d = r_pend_key;
        w_pend_vel_d = r_pend_vel;
        if (r_tstate == T_SETUP) begin
            w_pend_d = 1'b0;
        end
        if (w_req) begin
            w_pend_d     = 1'b1;
            w_pend_key_d = r_key;
            w_pend_vel_d = i_midi_byte[6:0];
        end
        unique case (r_tstate)
            T_IDLE: begin
                if (w_req || r_pend) begin
                    w_tstate_d = T_SETUP;
                end
            end
            T_SETUP: begin
                w_tstate_d = T_LOW;
                w_cnt_d    = '0;
            end
            T_LOW: begin
                if (r_cnt == CNT_LAST) begin
                    w_tstate_d = T_GAP;
                    w_cnt_d    = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            T_GAP: begin
                if (r_cnt == CNT_LAST) begin
                    w_tstate_d = (w_req || r_pend) ? T_SETUP : T_IDLE;
                    w_cnt_d    = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Address follows whichever note T_SETUP will load next cycle.
    assign w_rom_addr = w_req ? r_key : r_pend_key;

    kp_note_period_rom u_rom (
        .i_clk   (i_audio_clk),
        .i_key   (w_rom_addr),
        .o_delay (w_rom_data)
    );

    always_ff @(posedge i_audio_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pstate    <= P_IDLE;
            r_is_on     <= 1'b0;
            r_skip_two  <= 1'b0;
            r_key       <= '0;
            r_tstate    <= T_IDLE;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_key  <= '0;
            r_pend_vel  <= '0;
            r_trig      <= 1'b1;
            r_velocity  <= '0;
            r_delay     <= DEFAULT_DELAY;
            r_active    <= 1'b0;
            r_last_note <= '0;
        end else begin
            r_pstate   <= w_pstate_d;
            r_is_on    <= w_is_on_d;
            r_skip_two <= w_skip_two_d;
            r_key      <= w_key_d;
            r_tstate   <= w_tstate_d;
            r_cnt      <= w_cnt_d;
            r_pend     <= w_pend_d;
            r_pend_key <= w_pend_key_d;
            r_pend_vel <= w_pend_vel_d;
            r_trig     <= (w_tstate_d != T_LOW);
            if (r_tstate == T_SETUP) begin
                r_velocity  <= r_pend_vel;
                r_last_note <= r_pend_key;
                r_delay     <= w_rom_data;
                r_active    <= 1'b1;
            end else if (w_off && (r_key == r_last_note)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_trig         = r_trig;
    assign o_velocity     = r_velocity;
    assign o_delay_length = r_delay;
    assign o_note_active  = r_active;
    assign o_last_note    = r_last_note;

endmodule

// File: tb/tb_kp_midi_voice_ctrl.sv
// Scoreboard bench for kp_midi_voice_ctrl: expected notes queued at send time, checked on each trig pulse.
module tb_kp_midi_voice_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  midi_byte;
    logic        midi_valid;
    logic [3:0]  midi_chan;
    logic        trig;
    logic [6:0]  velocity;
    logic [11:0] delay_length;
    logic        note_active;
    logic [6:0]  last_note;

    kp_midi_voice_ctrl dut (
        .i_audio_clk    (clk),
        .i_reset_n      (rst_n),
        .i_midi_byte    (midi_byte),
        .i_midi_valid   (midi_valid),
        .i_midi_chan    (midi_chan),
        .o_trig         (trig),
        .o_velocity     (velocity),
        .o_delay_length (delay_length),
        .o_note_active  (note_active),
        .o_last_note    (last_note)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dly;
        int vel;
        int note;
        bit lat;
        int strobe;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   n_spurious = 0;
    int   last_strobe = 0;
    int   last_rise = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_delay(input int n);
        real p;
        int  d;
        p = 96000.0 / (440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)));
        d = $rtoi(p + 0.5);
        return (d > 4095) ? 4095 : d;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        midi_byte   = b;
        midi_valid  = 1'b1;
        last_strobe = cyc;
        @(negedge clk);
        midi_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic expect_note(input int key, input int vel, input bit lat);
        exp_t e;
        e.dly    = exp_delay(key);
        e.vel    = vel;
        e.note   = key;
        e.lat    = lat;
        e.strobe = last_strobe;
        sb.push_back(e);
    endtask

    task automatic settle(input string tag, input int n);
        repeat (n) @(negedge clk);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_spurious"}, n_spurious, 0);
    endtask

    // Pulse monitor: pops one expectation per falling trig edge.
    initial begin : mon
        exp_t e;
        logic prev;
        int   low;
        bit   rst_seen;
        bit   moved;
        int   dly0;
        int   vel0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !trig) begin
                if (sb.size() == 0) begin
                    n_spurious++;
                end else begin
                    e = sb.pop_front();
                    check("delay_length", int'(delay_length), e.dly);
                    check("velocity", int'(velocity), e.vel);
                    check("last_note", int'(last_note), e.note);
                    check("note_active", int'(note_active), 1);
                    if (e.lat) check("latency", cyc - e.strobe, 2);
                    else       check("pend_gap", cyc - last_rise, 17);
                end
                dly0     = int'(delay_length);
                vel0     = int'(velocity);
                low      = 1;
                rst_seen = 1'b0;
                moved    = 1'b0;
                while (!trig && low < 200) begin
                    @(negedge clk);
                    if (!rst_n) rst_seen = 1'b1;
                    if (!trig) begin
                        low++;
                        if (int'(delay_length) != dly0 || int'(velocity) != vel0) moved = 1'b1;
                    end
                end
                if (!rst_seen) begin
                    check("trig_low_len", low, 16);
                    check("stable_while_low", int'(moved), 0);
                end
                last_rise = cyc;
            end
            prev = trig;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int keys[6] = '{19, 33, 48, 72, 100, 108};
        rst_n      = 1'b0;
        midi_byte  = 8'h00;
        midi_valid = 1'b0;
        midi_chan  = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (20) @(negedge clk);
        check("rst_trig", int'(trig), 1);
        check("rst_delay", int'(delay_length), 218);
        check("rst_velocity", int'(velocity), 0);
        check("rst_active", int'(note_active), 0);
        check("rst_last_note", int'(last_note), 0);
        check("rst_spurious", n_spurious, 0);

        // Basic note-on
        send3(8'h90, 8'h3C, 8'h64);
        expect_note(60, 100, 1'b1);
        settle("t2", 45);
        check("t2_active", int'(note_active), 1);
        check("t2_last_note", int'(last_note), 60);

        // Running-status note-off by zero velocity
        send3(8'h90, 8'h45, 8'h40);
        expect_note(69, 64, 1'b1);
        settle("t3a", 45);
        send_byte(8'h45);
        send_byte(8'h00);
        settle("t3b", 45);
        check("t3_active", int'(note_active), 0);
        check("t3_delay", int'(delay_length), 218);
        check("t3_velocity", int'(velocity), 64);

        // Pending slot keeps only the newest request
        send3(8'h90, 8'h39, 8'h7F);
        expect_note(57, 127, 1'b1);
        send3(8'h90, 8'h51, 8'h20);
        send3(8'h90, 8'h00, 8'h10);
        expect_note(0, 16, 1'b0);
        settle("t4", 80);
        check("t4_delay", int'(delay_length), 4095);
        check("t4_velocity", int'(velocity), 16);

        // Foreign channel
        send3(8'h91, 8'h3C, 8'h64);
`ifdef KP_MIDI_OMNI_EN
        expect_note(60, 100, 1'b1);
`endif
        settle("t5", 45);

        // Realtime byte interleaved, then aborted message
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        expect_note(60, 100, 1'b1);
        settle("t6a", 45);
        send_byte(8'h90);
        send_byte(8'h3C);
        send3(8'hB0, 8'h07, 8'h64);
        settle("t6b", 45);

        // Reset in the middle of a pulse
        send3(8'h90, 8'h40, 8'h50);
        expect_note(64, 80, 1'b1);
        repeat (6) @(negedge clk);
        check("pre_rst_trig", int'(trig), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_trig", int'(trig), 1);
        check("midrst_delay", int'(delay_length), 218);
        check("midrst_velocity", int'(velocity), 0);
        check("midrst_active", int'(note_active), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Running status gone after reset; SysEx data discarded
        send_byte(8'h3C);
        send_byte(8'h64);
        send3(8'hF0, 8'h7E, 8'h3C);
        send_byte(8'h64);
        send_byte(8'hF7);
        send_byte(8'h3C);
        send_byte(8'h64);
        settle("t7", 45);
        check("t7_active", int'(note_active), 0);
        check("t7_delay", int'(delay_length), 218);

        // Highest channel and key
        midi_chan = 4'd15;
        send3(8'h9F, 8'h7F, 8'h01);
        expect_note(127, 1, 1'b1);
        settle("t8", 45);
        send3(8'h9F, 8'h10, 8'h00);
        repeat (4) @(negedge clk);
        check("t8_other_off", int'(note_active), 1);
        send3(8'h8F, 8'h7F, 8'h00);
        repeat (4) @(negedge clk);
        check("t8_note_off", int'(note_active), 0);

        // Period sweep via running status
        send_byte(8'h9F);
        foreach (keys[i]) begin
            send_byte(8'(keys[i]));
            send_byte(8'(keys[i] + 3));
            expect_note(keys[i], keys[i] + 3, 1'b1);
            settle("sweep", 45);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
